// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type, S-box table and Rcon lookup
// for the key-expansion block.
package aes_pkg;

  localparam int AES_NR       = 10;
  localparam int AES_BLK_W    = 128;
  localparam int AES_EXPKEY_W = 1408;

  typedef enum logic {
    IDLE,
    EXPAND
  } kx_state_e;

  // Forward S-box, entry 0 first.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for round i (1..10); 0 outside that range.
  function automatic logic [7:0] rcon_lut(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_schedule_step.sv
// One combinational AES-128 key-schedule round: previous round key plus
// Rcon in, next round key out.
module key_schedule_step
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [AES_BLK_W-1:0] prev_rk,
  input  logic [7:0]           rcon,
  output logic [AES_BLK_W-1:0] next_rk
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_rk;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_sbox
    assign sub[g*8 +: 8] = sbox(rot[g*8 +: 8]);
  end

  assign temp = sub ^ {rcon, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  assign next_rk = {n0, n1, n2, n3};

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key expansion, one round key per clock into an 11-entry store.
// Optional streaming tap of each written round key: define KEYEXP_RK_TAP_EN.
module key_expansion
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AES_BLK_W-1:0]    key_in,
  output logic [AES_EXPKEY_W-1:0] round_keys,
`ifdef KEYEXP_RK_TAP_EN
  output logic [AES_BLK_W-1:0]    rk_tap,
  output logic                    rk_tap_valid,
`endif
  output logic                    busy,
  output logic                    keys_valid,
  output logic                    done
);

  kx_state_e state_q, state_d;

  // Entry 0 sits at the MSB end so the packed store maps directly onto round_keys.
  logic [0:AES_NR][AES_BLK_W-1:0] rk_q;
  logic [3:0]                     cnt_q;
  logic [AES_BLK_W-1:0]           prev_rk, next_rk;
  logic                           last;

  assign prev_rk    = rk_q[cnt_q - 4'd1];
  assign last       = (cnt_q == NR[3:0]);
  assign round_keys = rk_q;

  key_schedule_step u_step (
    .prev_rk (prev_rk),
    .rcon    (rcon_lut(cnt_q)),
    .next_rk (next_rk)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXPAND;
      EXPAND:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q       <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
`ifdef KEYEXP_RK_TAP_EN
      rk_tap       <= '0;
      rk_tap_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef KEYEXP_RK_TAP_EN
      rk_tap_valid <= 1'b0;
`endif
      case (state_q)
        IDLE: if (start) begin
          rk_q       <= '0;
          rk_q[0]    <= key_in;
          cnt_q      <= 4'd1;
          busy       <= 1'b1;
          keys_valid <= 1'b0;
`ifdef KEYEXP_RK_TAP_EN
          rk_tap       <= key_in;
          rk_tap_valid <= 1'b1;
`endif
        end
        EXPAND: begin
          rk_q[cnt_q] <= next_rk;
          cnt_q       <= cnt_q + 4'd1;
`ifdef KEYEXP_RK_TAP_EN
          rk_tap       <= next_rk;
          rk_tap_valid <= 1'b1;
`endif
          if (last) begin
            cnt_q      <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/key_expansion.md
Name: key_expansion

Overview:
- Iterative AES-128 key schedule that generates the 1408-bit expanded key (11 round keys) consumed by the round datapath's key input.
- Sits directly upstream of the round/addroundkey stage.
- Generates one 128-bit round key per clock using a 4-byte SubWord, RotWord and Rcon step.
- Holds the expanded key stable until the next start.

Parameters:
- NR, 10, number of generated round keys after the cipher key (AES-128). Only the value 10 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request expansion of key_in. Sampled only when busy=0.
- key_in  in  128  cipher key. Byte 0 is at [127:120].
- round_keys  out  1408  expanded key. Round key i is at [1407-128*i -: 128], so rk0 occupies [1407:1280].
- busy  out  1  expansion in progress.
- keys_valid  out  1  round_keys complete and stable (level).
- done  out  1  one-cycle pulse when rk10 is written.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. rst has priority over start.
- Reset values: round_keys=0, busy=0, keys_valid=0, done=0, round counter=0, FSM=IDLE.
- FSM states: IDLE and EXPAND.
- IDLE with start=1, at edge E0:
  - rk0 <= key_in; rk1..rk10 <= 0.
  - counter <= 1; busy <= 1; keys_valid <= 0.
  - go to EXPAND.
- EXPAND, edges E1..E10 (counter = i):
  - temp = SubWord(RotWord(w3 of rk[i-1])) XOR {Rcon[i], 24'h0}.
  - w0' = w0 XOR temp; w1' = w1 XOR w0'; w2' = w2 XOR w1'; w3' = w3 XOR w2'.
  - Write rk[i] = {w0', w1', w2', w3'}; counter increments.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- At E10 (counter==10):
  - busy <= 0, keys_valid <= 1, done <= 1 for exactly one cycle.
  - return to IDLE.
- Latency: start sampled at E0; done and keys_valid visible after E10, i.e. 10 cycles after start acceptance.
- start during EXPAND: ignored. key_in is not re-sampled.
- start in IDLE while keys_valid=1: restarts expansion. keys_valid drops at E0.
- Back-to-back: start held high continuously restarts on the cycle after done.
- rst during EXPAND: aborts. All outputs return to reset values on that edge.
- round_keys changes only on E0..E10 edges. It is stable whenever keys_valid=1.
- Consumer contract: the round stage must not be started until keys_valid=1.

Optional Feature:
- Macro: KEYEXP_RK_TAP_EN.
- Defined: adds output ports rk_tap[127:0] and rk_tap_valid.
  - rk_tap_valid pulses on each edge E0..E10.
  - rk_tap carries the round key written on that edge (rk0..rk10), for streaming/pipelined consumers.
  - Both reset to 0.
- Undefined: ports and logic absent. Behaviour is otherwise identical.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10, AES_BLK_W=128, AES_EXPKEY_W=1408.
  - Rcon lookup function/constant array.
  - FSM state enum (IDLE, EXPAND).
- One natural sub-module, key_schedule_step: combinational, (prev_rk[127:0], rcon[7:0]) -> next_rk[127:0].
  - Contains four S-box byte lookups (shared sbox byte function from the package).
- The top level holds the FSM, counter and the 11-entry storage.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses exactly 10 cycles after start was sampled.
- All-zero key:
  - rk1 = 62636363626363636263636362636363.
  - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - keys_valid stays high until the next start.
- Start asserted again at E5 with a different key_in:
  - ignored; final keys match the first key.
  - a single done pulse; busy high continuously E0..E9.
- rst asserted at E4:
  - next cycle round_keys=0, busy=0, keys_valid=0, done=0.
  - a following start produces correct FIPS-197 keys.
- Restart from keys_valid=1 with a new key:
  - keys_valid falls at E0; rk1..rk10 read 0 until written.
  - correct new rk10 at E10.
- With KEYEXP_RK_TAP_EN:
  - 11 rk_tap_valid pulses per expansion.
  - rk_tap sequence equals rk0..rk10 of the FIPS-197 vector.
